// File: rtl/block_mem_responder.sv
// Block-transfer memory responder for the data cache.
// Fixed-latency 64x32 store with busywait handshake.
module block_mem_responder #(
  parameter int LATENCY = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [64];

  logic req;
  logic commit;

  assign req    = read | write;
  assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);

  // State, counter and latched request registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 6'd0;
      data_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic and busywait
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    busywait = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          busywait = 1'b1;
          addr_d   = address;
          data_d   = writedata;
          wr_d     = write;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        busywait = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!RESET) begin
      busywait = 1'b0;
    end
  end

  // Storage array: cleared on reset, written at commit
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (commit && wr_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  // Read data register: loaded at read commit, held otherwise
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rdata_q <= 32'h0;
    end else if (commit && !wr_q) begin
      rdata_q <= mem_q[addr_q];
    end
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder.
// Covers LATENCY=5 and LATENCY=1 builds.
module tb_block_mem_responder;

  localparam int L5 = 5;
  localparam int L1 = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;

  logic        rd5, wr5;
  logic [5:0]  a5;
  logic [31:0] d5, q5;
  logic        bw5;

  logic        rd1, wr1;
  logic [5:0]  a1;
  logic [31:0] d1, q1;
  logic        bw1;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  block_mem_responder #(.LATENCY(L5)) u5 (
    .CLK(CLK), .RESET(RESET),
    .read(rd5), .write(wr5),
    .address(a5), .writedata(d5),
    .readdata(q5), .busywait(bw5)
  );

  block_mem_responder #(.LATENCY(L1)) u1 (
    .CLK(CLK), .RESET(RESET),
    .read(rd1), .write(wr1),
    .address(a1), .writedata(d1),
    .readdata(q1), .busywait(bw1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One access on the LATENCY=5 instance; optional
  // mid-access input scramble and readdata check at DONE.
  task automatic acc5(input string tag,
                      input logic w, input logic r,
                      input logic [5:0] a,
                      input logic [31:0] d,
                      input bit scr,
                      input logic [31:0] exp_q);
    int hi;
    @(posedge CLK); #1;
    wr5 = w; rd5 = r; a5 = a; d5 = d;
    hi = 0;
    for (int i = 0; i <= L5; i++) begin
      @(negedge CLK);
      if (bw5 === 1'b1) hi++;
      if (scr && i == 2) begin
        a5 = 6'd20; d5 = 32'hFFFFFFFF;
      end
    end
    chk({tag, "_busy_hi"}, 32'(hi), 32'(L5 + 1));
    @(negedge CLK);
    chk({tag, "_busy_done"}, {31'b0, bw5}, 32'h0);
    chk({tag, "_rdata"}, q5, exp_q);
    wr5 = 1'b0; rd5 = 1'b0;
  endtask

  task automatic acc1(input string tag,
                      input logic w,
                      input logic [5:0] a,
                      input logic [31:0] d,
                      input logic [31:0] exp_q);
    int hi;
    @(posedge CLK); #1;
    wr1 = w; rd1 = ~w; a1 = a; d1 = d;
    hi = 0;
    for (int i = 0; i <= L1; i++) begin
      @(negedge CLK);
      if (bw1 === 1'b1) hi++;
    end
    chk({tag, "_busy_hi"}, 32'(hi), 32'(L1 + 1));
    @(negedge CLK);
    chk({tag, "_busy_done"}, {31'b0, bw1}, 32'h0);
    chk({tag, "_rdata"}, q1, exp_q);
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    wr5 = 0; rd5 = 1; a5 = 0; d5 = 0;
    wr1 = 0; rd1 = 0; a1 = 0; d1 = 0;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy_forced_low", {31'b0, bw5}, 32'h0);
    chk("rst_rdata", q5, 32'h0);
    chk("rst_rdata_l1", q1, 32'h0);
    rd5 = 0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    acc5("rd9", 0, 1, 6'd9, 32'h0, 0, 32'h0);
    acc5("wr3", 1, 0, 6'd3, 32'hDEADBEEF, 0, 32'h0);
    acc5("rd3", 0, 1, 6'd3, 32'h0, 0, 32'hDEADBEEF);
    acc5("rw7", 1, 1, 6'd7, 32'h12345678, 0,
         32'hDEADBEEF);
    acc5("rd7", 0, 1, 6'd7, 32'h0, 0, 32'h12345678);
    acc5("wr1", 1, 0, 6'd1, 32'hA5A5A5A5, 1,
         32'h12345678);
    acc5("rd1", 0, 1, 6'd1, 32'h0, 0, 32'hA5A5A5A5);
    acc5("rd20", 0, 1, 6'd20, 32'h0, 0, 32'h0);
    acc5("wr5a", 1, 0, 6'd5, 32'h11111111, 0, 32'h0);
    acc5("rd5a", 0, 1, 6'd5, 32'h0, 0, 32'h11111111);

    // Reset during cycle 3 of a write to 6'd5
    @(posedge CLK); #1;
    wr5 = 1; a5 = 6'd5; d5 = 32'h55AA55AA;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_busy_low", {31'b0, bw5}, 32'h0);
    wr5 = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_busy_low2", {31'b0, bw5}, 32'h0);
    chk("abort_rdata", q5, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_idle", {31'b0, bw5}, 32'h0);
    acc5("rd5b", 0, 1, 6'd5, 32'h0, 0, 32'h0);
    acc5("rd3b", 0, 1, 6'd3, 32'h0, 0, 32'h0);

    acc1("l1_wr63", 1, 6'd63, 32'h00000042, 32'h0);
    acc1("l1_rd63", 0, 6'd63, 32'h0, 32'h00000042);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
